// File: rtl/lif_array.sv
// N_CH-channel current-based leaky integrate-and-fire array with a shared threshold and refractory hold.
// Define LIF_ADAPT_EN to add a per-channel adaptive threshold offset that grows on each spike.
module lif_array #(
   parameter int WIDTH         = 8,
   parameter int N_CH          = 4,
   parameter int CUR_SHIFT     = 1,
   parameter int LEAK_SHIFT    = 2,
   parameter int REFRAC_CYCLES = 2,
   parameter int V_RESET       = 0,
   parameter int ADAPT_INC     = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [N_CH*WIDTH-1:0]  cur_in,
   input  logic [WIDTH-1:0]       threshold,
   output logic [N_CH-1:0]        spike,
   output logic [N_CH*WIDTH-1:0]  v_mem,
   output logic [N_CH-1:0]        refrac
);

   localparam int RC_W = (REFRAC_CYCLES > 0) ? $clog2(REFRAC_CYCLES + 1) : 1;
   localparam logic [RC_W-1:0]  RC_LOAD = RC_W'(REFRAC_CYCLES);
   localparam logic [RC_W-1:0]  RC_ONE  = RC_W'(1);
   localparam logic [WIDTH-1:0] V_RST   = WIDTH'(V_RESET);
   localparam logic [WIDTH:0]   A_INC   = (WIDTH + 1)'(ADAPT_INC);

   if (CUR_SHIFT >= WIDTH || LEAK_SHIFT >= WIDTH || ADAPT_INC < 0 || V_RESET < 0) begin : g_bad_params
      $error("lif_array: invalid parameter set");
   end

   // Sums are WIDTH+1 bits; the carry bit means the result overflowed and must clamp.
   function automatic logic [WIDTH-1:0] sat(input logic [WIDTH:0] x);
      return x[WIDTH] ? {WIDTH{1'b1}} : x[WIDTH-1:0];
   endfunction

   for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [WIDTH-1:0] i_q, i_d;
      logic [WIDTH-1:0] v_q, v_d;
      logic [RC_W-1:0]  rc_q, rc_d;
      logic             spike_q, spike_d;
      logic [WIDTH:0]   i_sum, v_sum;
      logic [WIDTH-1:0] v_int, thr_eff;
      logic             fire;
`ifdef LIF_ADAPT_EN
      logic [WIDTH-1:0] a_q, a_d;
      logic [WIDTH:0]   thr_sum, a_sum;
`endif

      always_comb begin
         i_sum   = {1'b0, i_q - (i_q >> CUR_SHIFT)} + {1'b0, cur_in[gi*WIDTH +: WIDTH]};
         // V integrates the current held before this step, giving the one-step input lag.
         v_sum   = {1'b0, v_q - (v_q >> LEAK_SHIFT)} + {1'b0, i_q};
         v_int   = sat(v_sum);
`ifdef LIF_ADAPT_EN
         thr_sum = {1'b0, threshold} + {1'b0, a_q};
         a_sum   = {1'b0, a_q} + A_INC;
         thr_eff = sat(thr_sum);
`else
         thr_eff = threshold;
`endif
         fire    = (rc_q == '0) && (v_int >= thr_eff);

         i_d     = i_q;
         v_d     = v_q;
         rc_d    = rc_q;
         spike_d = 1'b0;
`ifdef LIF_ADAPT_EN
         a_d     = a_q;
`endif
         if (en) begin
            i_d = sat(i_sum);
            if (rc_q != '0) begin
               v_d  = V_RST;
               rc_d = rc_q - RC_ONE;
            end else if (fire) begin
               v_d     = V_RST;
               rc_d    = RC_LOAD;
               spike_d = 1'b1;
            end else begin
               v_d = v_int;
            end
`ifdef LIF_ADAPT_EN
            if (fire) begin
               a_d = sat(a_sum);
            end else if (a_q != '0) begin
               a_d = a_q - 1'b1;
            end
`endif
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            i_q     <= '0;
            v_q     <= '0;
            rc_q    <= '0;
            spike_q <= 1'b0;
`ifdef LIF_ADAPT_EN
            a_q     <= '0;
`endif
         end else begin
            i_q     <= i_d;
            v_q     <= v_d;
            rc_q    <= rc_d;
            spike_q <= spike_d;
`ifdef LIF_ADAPT_EN
            a_q     <= a_d;
`endif
         end
      end

      assign spike[gi]                 = spike_q;
      assign v_mem[gi*WIDTH +: WIDTH]  = v_q;
      assign refrac[gi]                = (rc_q != '0);
   end

endmodule

// File: tb/tb_lif_array.sv
// Self-checking bench for lif_array (N_CH=2, default widths): vector table, corner sequences, random vs model.
module tb_lif_array;
   localparam int N = 2, W = 8, CS = 1, LS = 2, RCY = 2, VR = 0, AINC = 16, MAXV = 255;

   logic           clk = 1'b0;
   logic           rst, en;
   logic [N*W-1:0] cur_in;
   logic [W-1:0]   threshold;
   logic [N-1:0]   spike, refrac;
   logic [N*W-1:0] v_mem;

   lif_array #(
      .WIDTH(W), .N_CH(N), .CUR_SHIFT(CS), .LEAK_SHIFT(LS),
      .REFRAC_CYCLES(RCY), .V_RESET(VR), .ADAPT_INC(AINC)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .cur_in(cur_in), .threshold(threshold),
      .spike(spike), .v_mem(v_mem), .refrac(refrac)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural reference: plain integers per neuron.
   int     mi[N], mv[N], mrc[N], ma[N];
   bit [N-1:0] mspk;

   function automatic int sat(input int x);
      return (x > MAXV) ? MAXV : x;
   endfunction

   task automatic model_edge();
      int cur, vint, thr;
      if (rst) begin
         for (int c = 0; c < N; c++) begin
            mi[c] = 0; mv[c] = 0; mrc[c] = 0; ma[c] = 0;
         end
         mspk = '0;
      end else if (!en) begin
         mspk = '0;
      end else begin
         for (int c = 0; c < N; c++) begin
            cur  = int'(cur_in[c*W +: W]);
            vint = sat(mv[c] - mv[c] / (2 ** LS) + mi[c]);
            mi[c] = sat(mi[c] - mi[c] / (2 ** CS) + cur);
            thr  = int'(threshold);
`ifdef LIF_ADAPT_EN
            thr  = sat(thr + ma[c]);
`endif
            mspk[c] = 1'b0;
            if (mrc[c] > 0) begin
               mv[c]  = VR;
               mrc[c] = mrc[c] - 1;
            end else if (vint >= thr) begin
               mv[c]   = VR;
               mrc[c]  = RCY;
               mspk[c] = 1'b1;
            end else begin
               mv[c] = vint;
            end
`ifdef LIF_ADAPT_EN
            if (mspk[c]) ma[c] = sat(ma[c] + AINC);
            else if (ma[c] > 0) ma[c] = ma[c] - 1;
`endif
         end
      end
   endtask

   task automatic check_model(input string name);
      logic [N*W-1:0] ev;
      logic [N-1:0]   erf;
      for (int c = 0; c < N; c++) begin
         ev[c*W +: W] = W'(mv[c]);
         erf[c]       = (mrc[c] != 0);
      end
      n_tests++;
      if (spike !== mspk || v_mem !== ev || refrac !== erf) begin
         n_fail++;
         $display("FAIL %s: got spike=%b v_mem=%h refrac=%b, want spike=%b v_mem=%h refrac=%b",
                  name, spike, v_mem, refrac, mspk, ev, erf);
      end
   endtask

   task automatic check_const(input string name, input bit [N-1:0] es, input int ev0, input int ev1,
                              input bit [N-1:0] erf);
      logic [N*W-1:0] ev;
      ev = {W'(ev1), W'(ev0)};
      n_tests++;
      if (spike !== es || v_mem !== ev || refrac !== erf) begin
         n_fail++;
         $display("FAIL %s: got spike=%b v_mem=%h refrac=%b, want spike=%b v_mem=%h refrac=%b",
                  name, spike, v_mem, refrac, es, ev, erf);
      end
   endtask

   // One clock: drive inputs, advance model on the edge, sample 1 time unit later.
   task automatic cyc(input bit r, input bit e, input int c0, input int c1, input int thr, input string name);
      rst       = r;
      en        = e;
      cur_in    = {W'(c1), W'(c0)};
      threshold = W'(thr);
      @(posedge clk);
      model_edge();
      #1;
      check_model(name);
      $display("[TB] %s rst=%0b en=%0b cur=%0d/%0d thr=%0d -> spike=%b v_mem=%h refrac=%b",
               name, r, e, c0, c1, thr, spike, v_mem, refrac);
   endtask

   typedef struct {
      bit          r;
      bit          e;
      int          c0;
      int          c1;
      int          thr;
      bit [N-1:0]  spk;
      int          v0;
      int          v1;
      bit [N-1:0]  rf;
   } vec_t;

   function automatic vec_t mk(input bit r, input bit e, input int c0, input int c1, input int thr,
                               input bit [N-1:0] spk, input int v0, input int v1, input bit [N-1:0] rf);
      vec_t t;
      t.r = r; t.e = e; t.c0 = c0; t.c1 = c1; t.thr = thr;
      t.spk = spk; t.v0 = v0; t.v1 = v1; t.rf = rf;
      return t;
   endfunction

   vec_t tbl[$];

   initial begin
      int thr_r, c0, c1;

      // Integrate-and-fire, reset, then the same run with en toggled between steps.
      tbl.push_back(mk(0, 1, 40, 0, 100, 2'b00,  0, 0, 2'b00));
      tbl.push_back(mk(0, 1, 40, 0, 100, 2'b00, 40, 0, 2'b00));
      tbl.push_back(mk(0, 1, 40, 0, 100, 2'b00, 90, 0, 2'b00));
      tbl.push_back(mk(0, 1, 40, 0, 100, 2'b01,  0, 0, 2'b01));
      tbl.push_back(mk(0, 1, 40, 0, 100, 2'b00,  0, 0, 2'b01));
      tbl.push_back(mk(0, 1, 40, 0, 100, 2'b00,  0, 0, 2'b00));
      tbl.push_back(mk(0, 1, 40, 0, 100, 2'b00, 79, 0, 2'b00));
      tbl.push_back(mk(1, 1, 40, 0, 100, 2'b00,  0, 0, 2'b00));
      tbl.push_back(mk(0, 1, 40, 0, 100, 2'b00,  0, 0, 2'b00));
      tbl.push_back(mk(0, 0, 40, 0, 100, 2'b00,  0, 0, 2'b00));
      tbl.push_back(mk(0, 1, 40, 0, 100, 2'b00, 40, 0, 2'b00));
      tbl.push_back(mk(0, 0, 40, 0, 100, 2'b00, 40, 0, 2'b00));
      tbl.push_back(mk(0, 1, 40, 0, 100, 2'b00, 90, 0, 2'b00));
      tbl.push_back(mk(0, 0, 40, 0, 100, 2'b00, 90, 0, 2'b00));
      tbl.push_back(mk(0, 1, 40, 0, 100, 2'b01,  0, 0, 2'b01));
      tbl.push_back(mk(0, 0, 40, 0, 100, 2'b00,  0, 0, 2'b01));

      // Reset with nonzero input, then idle.
      for (int k = 0; k < 2; k++) begin
         cyc(1, 1, 50, 60, 100, "reset");
         check_const("reset_const", 2'b00, 0, 0, 2'b00);
      end
      for (int k = 0; k < 10; k++) begin
         cyc(0, 1, 0, 0, 100, "idle");
         check_const("idle_const", 2'b00, 0, 0, 2'b00);
      end

      cyc(1, 1, 0, 0, 100, "pre_table_reset");
      foreach (tbl[k]) begin
         cyc(tbl[k].r, tbl[k].e, tbl[k].c0, tbl[k].c1, tbl[k].thr, $sformatf("vec%0d", k));
         check_const($sformatf("vec%0d_const", k), tbl[k].spk, tbl[k].v0, tbl[k].v1, tbl[k].rf);
      end

      // Saturation: overflowing sums must clamp, not wrap.
      cyc(1, 1, 0, 0, 255, "sat_reset");
      cyc(0, 1, 200, 0, 255, "sat_a1");
      check_const("sat_a1_const", 2'b00, 0, 0, 2'b00);
      cyc(0, 1, 200, 0, 255, "sat_a2");
      check_const("sat_a2_const", 2'b00, 200, 0, 2'b00);
      cyc(0, 1, 200, 0, 255, "sat_a3");
      check_const("sat_a3_fire", 2'b01, 0, 0, 2'b01);
      cyc(1, 1, 0, 0, 255, "sat_reset2");
      cyc(0, 1, 255, 0, 255, "sat_b1");
      check_const("sat_b1_const", 2'b00, 0, 0, 2'b00);
      cyc(0, 1, 255, 0, 255, "sat_b2");
      check_const("sat_b2_fire", 2'b01, 0, 0, 2'b01);

      // Threshold 0: simultaneous spikes every third step, then reset mid-refractory.
      cyc(1, 1, 0, 0, 0, "thr0_reset");
      cyc(0, 1, 20, 20, 0, "thr0_s1"); check_const("thr0_s1_const", 2'b11, 0, 0, 2'b11);
      cyc(0, 1, 20, 20, 0, "thr0_s2"); check_const("thr0_s2_const", 2'b00, 0, 0, 2'b11);
      cyc(0, 1, 20, 20, 0, "thr0_s3"); check_const("thr0_s3_const", 2'b00, 0, 0, 2'b00);
      cyc(0, 1, 20, 20, 0, "thr0_s4"); check_const("thr0_s4_const", 2'b11, 0, 0, 2'b11);
      cyc(0, 1, 20, 20, 0, "thr0_s5"); check_const("thr0_s5_const", 2'b00, 0, 0, 2'b11);
      cyc(0, 1, 20, 20, 0, "thr0_s6"); check_const("thr0_s6_const", 2'b00, 0, 0, 2'b00);
      cyc(0, 1, 20, 20, 0, "thr0_s7");
      cyc(0, 1, 20, 20, 0, "thr0_s8"); check_const("thr0_s8_refrac", 2'b00, 0, 0, 2'b11);
      cyc(1, 1, 20, 20, 0, "thr0_midreset"); check_const("thr0_midreset_const", 2'b00, 0, 0, 2'b00);

      // Long constant-drive run: exercises repeated spiking (and threshold adaptation when built in).
      for (int k = 0; k < 40; k++) cyc(0, 1, 40, 0, 100, "adapt_run");

      // Randomized traffic against the reference model.
      cyc(1, 1, 0, 0, 100, "rand_reset");
      thr_r = 100;
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 99) < 5) thr_r = $urandom_range(0, 255);
         c0 = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 60) : $urandom_range(0, 255);
         c1 = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 60) : $urandom_range(0, 255);
         cyc($urandom_range(0, 99) < 2, $urandom_range(0, 3) != 0, c0, c1, thr_r, "rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
